// File: rtl/jedro_1_core.sv
`default_nettype none
// ============================================================================
//  Module      : jedro_1_core (with helper jedro_1_core_regfile)
//  Description : Minimal in-order RV32I integer core, three stages
//                (fetch / decode-execute / writeback). Supports LUI, AUIPC,
//                OP-IMM, OP, LB/LH/LW/LBU/LHU and SB/SH/SW. Any other
//                encoding is illegal: it raises a sticky flag and freezes
//                the pc and pipeline until reset.
//  Optional    : JEDRO_1_RETIRE_CNT_EN adds retire_cnt_o, a 32-bit count
//                of instructions committed in writeback.
//  Ports       : clk_i, rst_i (sync, active-high)
//                instr_addr_o / instr_rdata_i   : 1-cycle latency ROM
//                data_addr_o / data_we_o / data_wdata_o / data_rdata_i
//                                               : 1-cycle latency byte RAM
//                illegal_instr_o                : sticky illegal flag
//                retire_cnt_o (optional)        : committed count
//  Revision    : 1.0  initial release
// ============================================================================

// Register file: 32 x DATA_WIDTH, two combinational read ports, one write
// port. x0 is cleared by reset and never written, so it always reads 0.
module jedro_1_core_regfile #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [4:0]            i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [4:0]            i_raddr1,
    input  logic [4:0]            i_raddr2,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2
);
    logic [DATA_WIDTH-1:0] regfile [0:31];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) begin
                regfile[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            regfile[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = regfile[i_raddr1];
    assign o_rdata2 = regfile[i_raddr2];
endmodule

module jedro_1_core #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic [31:0]           instr_rdata_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic [3:0]            data_we_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
`ifdef JEDRO_1_RETIRE_CNT_EN
    output logic [31:0]           retire_cnt_o,
`endif
    output logic                  illegal_instr_o
);
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE = 7'b0100011;
    localparam logic [6:0] c_F7_ZERO   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;

    // ---------------- fetch / DE pipeline state ----------------
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_de_pc;
    logic                  r_de_valid;
    logic                  r_halt;

    // ---------------- writeback stage state ----------------
    logic                  r_wb_valid;
    logic [4:0]            r_wb_rd;
    logic [DATA_WIDTH-1:0] r_wb_result;
    logic                  r_wb_load;
    logic [2:0]            r_wb_funct3;
    logic [1:0]            r_wb_lane;

    // ---------------- decode fields ----------------
    logic [6:0]            w_opcode;
    logic [4:0]            w_rd;
    logic [2:0]            w_funct3;
    logic [4:0]            w_rs1;
    logic [4:0]            w_rs2;
    logic [6:0]            w_funct7;
    logic [DATA_WIDTH-1:0] w_imm_i;
    logic [DATA_WIDTH-1:0] w_imm_s;
    logic [DATA_WIDTH-1:0] w_imm_u;

    logic w_is_lui, w_is_auipc, w_is_opimm, w_is_op, w_is_load, w_is_store;
    logic w_dec_legal;
    logic w_de_go;
    logic w_de_exec;
    logic w_illegal_now;

    logic [DATA_WIDTH-1:0] w_rf_rdata1;
    logic [DATA_WIDTH-1:0] w_rf_rdata2;
    logic [DATA_WIDTH-1:0] w_rs1_val;
    logic [DATA_WIDTH-1:0] w_rs2_val;
    logic [DATA_WIDTH-1:0] w_alu_b;
    logic [4:0]            w_shamt;
    logic                  w_alt;
    logic [DATA_WIDTH-1:0] w_alu_res;
    logic [DATA_WIDTH-1:0] w_result;

    logic [DATA_WIDTH-1:0] w_mem_addr;
    logic [3:0]            w_store_we;
    logic [DATA_WIDTH-1:0] w_store_data;

    logic [7:0]            w_ld_byte;
    logic [15:0]           w_ld_half;
    logic [DATA_WIDTH-1:0] w_ld_val;
    logic [DATA_WIDTH-1:0] w_wb_data;
    logic                  w_wb_we;

    assign w_opcode = instr_rdata_i[6:0];
    assign w_rd     = instr_rdata_i[11:7];
    assign w_funct3 = instr_rdata_i[14:12];
    assign w_rs1    = instr_rdata_i[19:15];
    assign w_rs2    = instr_rdata_i[24:20];
    assign w_funct7 = instr_rdata_i[31:25];

    assign w_imm_i = {{20{instr_rdata_i[31]}}, instr_rdata_i[31:20]};
    assign w_imm_s = {{20{instr_rdata_i[31]}}, instr_rdata_i[31:25], instr_rdata_i[11:7]};
    assign w_imm_u = {instr_rdata_i[31:12], 12'h000};

    assign w_is_lui   = (w_opcode == c_OPC_LUI);
    assign w_is_auipc = (w_opcode == c_OPC_AUIPC);
    assign w_is_opimm = (w_opcode == c_OPC_OPIMM);
    assign w_is_op    = (w_opcode == c_OPC_OP);
    assign w_is_load  = (w_opcode == c_OPC_LOAD);
    assign w_is_store = (w_opcode == c_OPC_STORE);

    always_comb begin
        w_dec_legal = 1'b0;
        case (w_opcode)
            c_OPC_LUI, c_OPC_AUIPC: w_dec_legal = 1'b1;
            c_OPC_OPIMM: begin
                case (w_funct3)
                    3'b001:  w_dec_legal = (w_funct7 == c_F7_ZERO);
                    3'b101:  w_dec_legal = (w_funct7 == c_F7_ZERO) || (w_funct7 == c_F7_ALT);
                    default: w_dec_legal = 1'b1;
                endcase
            end
            c_OPC_OP: begin
                w_dec_legal = (w_funct7 == c_F7_ZERO) ||
                              ((w_funct7 == c_F7_ALT) &&
                               ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
            end
            c_OPC_LOAD:  w_dec_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) &&
                                       (w_funct3 != 3'b111);
            c_OPC_STORE: w_dec_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                                       (w_funct3 == 3'b010);
            default:     w_dec_legal = 1'b0;
        endcase
    end

    // DE is live only while not halted and not in a reset cycle, so nothing
    // in flight can write memory or the regfile while rst_i is high.
    assign w_de_go       = r_de_valid & ~r_halt & ~rst_i;
    assign w_de_exec     = w_de_go & w_dec_legal;
    assign w_illegal_now = w_de_go & ~w_dec_legal;

    jedro_1_core_regfile #(
        .DATA_WIDTH (DATA_WIDTH)
    ) regfile_inst (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_we     (w_wb_we),
        .i_waddr  (r_wb_rd),
        .i_wdata  (w_wb_data),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rf_rdata1),
        .o_rdata2 (w_rf_rdata2)
    );

    // The regfile write happens at the end of the W cycle, so the instruction
    // right behind it in DE must take the W value directly.
    assign w_rs1_val = (r_wb_valid && (r_wb_rd != 5'd0) && (r_wb_rd == w_rs1)) ? w_wb_data : w_rf_rdata1;
    assign w_rs2_val = (r_wb_valid && (r_wb_rd != 5'd0) && (r_wb_rd == w_rs2)) ? w_wb_data : w_rf_rdata2;

    // ---------------- ALU ----------------
    assign w_alu_b = w_is_op ? w_rs2_val : w_imm_i;
    assign w_shamt = w_alu_b[4:0];
    // For OP-IMM, bit 30 belongs to the immediate except on right shifts.
    assign w_alt   = w_is_op ? w_funct7[5] : ((w_funct3 == 3'b101) && w_funct7[5]);

    always_comb begin
        w_alu_res = '0;
        case (w_funct3)
            3'b000: w_alu_res = w_alt ? (w_rs1_val - w_alu_b) : (w_rs1_val + w_alu_b);
            3'b001: w_alu_res = w_rs1_val << w_shamt;
            3'b010: w_alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_rs1_val) < $signed(w_alu_b))};
            3'b011: w_alu_res = {{(DATA_WIDTH-1){1'b0}}, (w_rs1_val < w_alu_b)};
            3'b100: w_alu_res = w_rs1_val ^ w_alu_b;
            3'b101: begin
                if (w_alt) begin
                    w_alu_res = $unsigned($signed(w_rs1_val) >>> w_shamt);
                end else begin
                    w_alu_res = w_rs1_val >> w_shamt;
                end
            end
            3'b110: w_alu_res = w_rs1_val | w_alu_b;
            3'b111: w_alu_res = w_rs1_val & w_alu_b;
            default: w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_result = w_alu_res;
        if (w_is_lui) begin
            w_result = w_imm_u;
        end else if (w_is_auipc) begin
            w_result = DATA_WIDTH'(r_de_pc) + w_imm_u;
        end
    end

    // ---------------- memory access ----------------
    assign w_mem_addr = w_rs1_val + (w_is_store ? w_imm_s : w_imm_i);

    always_comb begin
        w_store_we   = 4'b0000;
        w_store_data = w_rs2_val;
        case (w_funct3[1:0])
            2'b00: begin
                w_store_we   = 4'b0001 << w_mem_addr[1:0];
                w_store_data = {4{w_rs2_val[7:0]}};
            end
            2'b01: begin
                w_store_we   = w_mem_addr[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{w_rs2_val[15:0]}};
            end
            2'b10: w_store_we = 4'b1111;
            default: w_store_we = 4'b0000;
        endcase
    end

    assign data_addr_o  = (w_de_exec && (w_is_load || w_is_store)) ?
                          ADDR_WIDTH'({w_mem_addr[DATA_WIDTH-1:2], 2'b00}) : '0;
    assign data_we_o    = (w_de_exec && w_is_store) ? w_store_we : 4'b0000;
    assign data_wdata_o = (w_de_exec && w_is_store) ? w_store_data : '0;

    // ---------------- fetch and DE registers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc       <= BOOT_ADDR;
            r_de_pc    <= BOOT_ADDR;
            r_de_valid <= 1'b0;
            r_halt     <= 1'b0;
        end else if (r_halt || w_illegal_now) begin
            r_halt     <= 1'b1;
        end else begin
            r_pc       <= r_pc + ADDR_WIDTH'(4);
            r_de_pc    <= r_pc;
            r_de_valid <= 1'b1;
        end
    end

    assign instr_addr_o    = r_pc;
    assign illegal_instr_o = ~rst_i & (r_halt | w_illegal_now);

    // ---------------- writeback ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_result <= '0;
            r_wb_load   <= 1'b0;
            r_wb_funct3 <= 3'b000;
            r_wb_lane   <= 2'b00;
        end else begin
            r_wb_valid  <= w_de_exec;
            // Stores carry imm bits in the rd field; retire them with rd = x0.
            r_wb_rd     <= w_is_store ? 5'd0 : w_rd;
            r_wb_result <= w_result;
            r_wb_load   <= w_is_load;
            r_wb_funct3 <= w_funct3;
            r_wb_lane   <= w_mem_addr[1:0];
        end
    end

    always_comb begin
        w_ld_byte = data_rdata_i[7:0];
        case (r_wb_lane)
            2'b00: w_ld_byte = data_rdata_i[7:0];
            2'b01: w_ld_byte = data_rdata_i[15:8];
            2'b10: w_ld_byte = data_rdata_i[23:16];
            2'b11: w_ld_byte = data_rdata_i[31:24];
            default: w_ld_byte = data_rdata_i[7:0];
        endcase
    end

    assign w_ld_half = r_wb_lane[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

    always_comb begin
        w_ld_val = data_rdata_i;
        case (r_wb_funct3)
            3'b000:  w_ld_val = {{(DATA_WIDTH-8){w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_val = {{(DATA_WIDTH-16){w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_val = {{(DATA_WIDTH-8){1'b0}}, w_ld_byte};
            3'b101:  w_ld_val = {{(DATA_WIDTH-16){1'b0}}, w_ld_half};
            default: w_ld_val = data_rdata_i;
        endcase
    end

    assign w_wb_data = r_wb_load ? w_ld_val : r_wb_result;
    assign w_wb_we   = r_wb_valid & ~rst_i;

`ifdef JEDRO_1_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_retire_cnt <= 32'd0;
        end else begin
            r_retire_cnt <= r_retire_cnt + {31'd0, r_wb_valid};
        end
    end

    assign retire_cnt_o = r_retire_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jedro_1_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jedro_1_core
//  Description : Self-checking bench for jedro_1_core. Programs run from a
//                ROM model against a byte-write RAM model; results are
//                compared against an instruction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jedro_1_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata;
    logic [31:0] data_addr;
    logic [3:0]  data_we;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        illegal;
`ifdef JEDRO_1_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    always #5 clk = ~clk;

    jedro_1_core dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .instr_addr_o    (instr_addr),
        .instr_rdata_i   (instr_rdata),
        .data_addr_o     (data_addr),
        .data_we_o       (data_we),
        .data_wdata_o    (data_wdata),
        .data_rdata_i    (data_rdata),
`ifdef JEDRO_1_RETIRE_CNT_EN
        .retire_cnt_o    (retire_cnt),
`endif
        .illegal_instr_o (illegal)
    );

    // ---------------- memory models ----------------
    logic [31:0] rom      [0:63];
    logic [31:0] ram      [0:15];
    logic [31:0] ram_init [0:15];
    logic [31:0] prog     [$];
    logic [3:0]  last_we  = 4'h0;
    logic [31:0] last_sa  = 32'h0;

    always @(posedge clk) begin
        instr_rdata <= rom[instr_addr[7:2]];
        data_rdata  <= ram[data_addr[5:2]];
        if (rst) begin
            ram <= ram_init;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (data_we[b]) ram[data_addr[5:2]][8*b +: 8] <= data_wdata[8*b +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && data_we != 4'h0) begin
            last_we <= data_we;
            last_sa <= data_addr;
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        r   = $urandom;
        rd  = {2'b00, r[2:0]};
        rs1 = {2'b00, r[5:3]};
        rs2 = {2'b00, r[8:6]};
        f3  = r[11:9];
        imm = r[23:12];
        case (4'($urandom_range(0, 9)))
            4'd0: return enc_u(r[31:12], rd, 7'h37);
            4'd1: return enc_u(r[31:12], rd, 7'h17);
            4'd2, 4'd3, 4'd4: begin
                if (f3 == 3'd1) imm = {7'h00, r[16:12]};
                if (f3 == 3'd5) imm = {(r[30] ? 7'h20 : 7'h00), r[16:12]};
                return enc_i(imm, rs1, f3, rd, 7'h13);
            end
            4'd5, 4'd6, 4'd7: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[30]) ? 7'h20 : 7'h00;
                return enc_r(f7, rs2, rs1, f3, rd);
            end
            4'd8: begin
                case (r[27:25] % 3'd5)
                    3'd0: f3 = 3'd0;
                    3'd1: f3 = 3'd1;
                    3'd2: f3 = 3'd2;
                    3'd3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
                return enc_i({6'd0, r[17:12]}, 5'd0, f3, rd, 7'h03);
            end
            default: return enc_s({6'd0, r[17:12]}, rs2, 5'd0, {1'b0, (r[10:9] == 2'b11) ? 2'b10 : r[10:9]});
        endcase
    endfunction

    // ---------------- reference model (instruction-set level) ----------------
    logic [31:0] m_x   [0:31];
    logic [7:0]  m_mem [0:63];
    logic [31:0] m_halt_pc;
    int          m_retired;

    task automatic model_run();
        logic [31:0] pc, ins, a, b, res, addr, imm_i, v;
        logic [4:0]  rd, rs1, rs2, sh;
        logic [5:0]  hb, wb;
        logic [2:0]  f3;
        logic [6:0]  f7, op;
        logic        wr, halt;
        for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
        for (int w = 0; w < 16; w++)
            for (int k = 0; k < 4; k++) m_mem[4*w+k] = ram_init[w][8*k +: 8];
        pc = 32'h0; m_retired = 0; halt = 1'b0;
        while (!halt) begin
            ins = rom[pc[7:2]];
            op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
            rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
            imm_i = {{20{ins[31]}}, ins[31:20]};
            res = 32'h0; wr = 1'b1;
            addr = m_x[rs1] + ((op == 7'h23) ? {{20{ins[31]}}, ins[31:25], ins[11:7]} : imm_i);
            hb = {addr[5:1], 1'b0};
            wb = {addr[5:2], 2'b00};
            case (op)
                7'h37: res = {ins[31:12], 12'h000};
                7'h17: res = pc + {ins[31:12], 12'h000};
                7'h13, 7'h33: begin
                    a = m_x[rs1];
                    b = (op == 7'h33) ? m_x[rs2] : imm_i;
                    sh = b[4:0];
                    case (f3)
                        3'd0: res = (op == 7'h33 && f7 == 7'h20) ? a - b : a + b;
                        3'd1: res = a << sh;
                        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: res = (a < b) ? 32'd1 : 32'd0;
                        3'd4: res = a ^ b;
                        3'd5: begin
                            if (f7 == 7'h20) res = $signed(a) >>> sh;
                            else             res = a >> sh;
                        end
                        3'd6: res = a | b;
                        default: res = a & b;
                    endcase
                end
                7'h03: begin
                    case (f3)
                        3'd0: res = {{24{m_mem[addr[5:0]][7]}}, m_mem[addr[5:0]]};
                        3'd4: res = {24'h0, m_mem[addr[5:0]]};
                        3'd1: res = {{16{m_mem[hb+6'd1][7]}}, m_mem[hb+6'd1], m_mem[hb]};
                        3'd5: res = {16'h0, m_mem[hb+6'd1], m_mem[hb]};
                        default: res = {m_mem[wb+6'd3], m_mem[wb+6'd2], m_mem[wb+6'd1], m_mem[wb]};
                    endcase
                end
                7'h23: begin
                    wr = 1'b0;
                    v = m_x[rs2];
                    case (f3)
                        3'd0: m_mem[addr[5:0]] = v[7:0];
                        3'd1: begin m_mem[hb] = v[7:0]; m_mem[hb+6'd1] = v[15:8]; end
                        default: begin
                            m_mem[wb] = v[7:0];        m_mem[wb+6'd1] = v[15:8];
                            m_mem[wb+6'd2] = v[23:16]; m_mem[wb+6'd3] = v[31:24];
                        end
                    endcase
                end
                default: halt = 1'b1;
            endcase
            if (halt) begin
                m_halt_pc = pc + 32'd4;
            end else begin
                if (wr && rd != 5'd0) m_x[rd] = res;
                m_retired++;
                pc = pc + 32'd4;
                if (pc >= 32'd256) begin
                    halt = 1'b1;
                    m_halt_pc = pc;
                end
            end
        end
    endtask

    // Load the program (padded with JAL), hold reset, check reset state.
    task automatic start_prog(input string name);
        int nz;
        for (int i = 0; i < 64; i++) rom[i] = (i < prog.size()) ? prog[i] : 32'h0000_006F;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nz = 0;
        for (int i = 1; i < 32; i++) if (dut.regfile_inst.regfile[i] !== 32'h0) nz++;
        chk({name, " rst regs_nonzero"}, nz, 32'd0);
        chk({name, " rst instr_addr"}, instr_addr, 32'h0);
        chk({name, " rst data_we"}, {28'h0, data_we}, 32'h0);
        chk({name, " rst data_addr"}, data_addr, 32'h0);
        chk({name, " rst data_wdata"}, data_wdata, 32'h0);
        chk({name, " rst illegal"}, {31'h0, illegal}, 32'h0);
`ifdef JEDRO_1_RETIRE_CNT_EN
        chk({name, " rst retire_cnt"}, retire_cnt, 32'h0);
`endif
        model_run();
    endtask

    // Run to completion and compare architectural state to the model.
    task automatic finish_prog(input string name);
        logic [31:0] w;
        repeat (prog.size() + 8) @(negedge clk);
        chk({name, " illegal"}, {31'h0, illegal}, 32'h1);
        chk({name, " frozen_pc"}, instr_addr, m_halt_pc);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s x%0d", name, i), dut.regfile_inst.regfile[i], m_x[i]);
        for (int i = 0; i < 16; i++) begin
            w = {m_mem[4*i+3], m_mem[4*i+2], m_mem[4*i+1], m_mem[4*i]};
            chk($sformatf("%s ram[%0d]", name, i), ram[i], w);
        end
`ifdef JEDRO_1_RETIRE_CNT_EN
        chk({name, " retire_cnt"}, retire_cnt, 32'(m_retired));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ram_init[i] = 32'h0;

        // Step 1: signed/unsigned compares
        prog = {};
        prog.push_back(enc_i(12'd5,    5'd0, 3'd0, 5'd3, 7'h13));   // ADDI x3,x0,5
        prog.push_back(enc_i(12'hFFD,  5'd0, 3'd0, 5'd4, 7'h13));   // ADDI x4,x0,-3
        prog.push_back(enc_r(7'h00, 5'd4, 5'd3, 3'd2, 5'd1));       // SLT x1,x3,x4
        prog.push_back(enc_r(7'h00, 5'd3, 5'd4, 3'd2, 5'd2));       // SLT x2,x4,x3
        prog.push_back(enc_r(7'h00, 5'd3, 5'd4, 3'd3, 5'd5));       // SLTU x5,x4,x3
        prog.push_back(enc_i(12'hFFF,  5'd3, 3'd3, 5'd6, 7'h13));   // SLTIU x6,x3,-1
        prog.push_back(enc_i(12'd0,    5'd4, 3'd2, 5'd7, 7'h13));   // SLTI x7,x4,0
        start_prog("cmp");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("cmp running illegal", {31'h0, illegal}, 32'h0);
        finish_prog("cmp");
        chk("cmp x1", dut.regfile_inst.regfile[1], 32'h0);
        chk("cmp x2", dut.regfile_inst.regfile[2], 32'h1);
        chk("cmp x5", dut.regfile_inst.regfile[5], 32'h0);
        chk("cmp x6", dut.regfile_inst.regfile[6], 32'h1);
        chk("cmp x7", dut.regfile_inst.regfile[7], 32'h1);

        // Step 2: back-to-back dependencies through forwarding
        prog = {};
        prog.push_back(enc_i(12'd7, 5'd0, 3'd0, 5'd1, 7'h13));      // ADDI x1,x0,7
        prog.push_back(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2));       // ADD x2,x1,x1
        prog.push_back(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd3));       // SUB x3,x2,x1
        start_prog("fwd");
        rst = 1'b0;
        finish_prog("fwd");
        chk("fwd x2", dut.regfile_inst.regfile[2], 32'd14);
        chk("fwd x3", dut.regfile_inst.regfile[3], 32'd7);

        // Step 3: byte store, sign/zero loads, word load
        prog = {};
        prog.push_back(enc_i(12'h07F, 5'd0, 3'd0, 5'd1, 7'h13));    // ADDI x1,x0,0x7F
        prog.push_back(enc_s(12'd1, 5'd1, 5'd0, 3'd0));             // SB x1,1(x0)
        prog.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'h03));      // LB x2,1(x0)
        prog.push_back(enc_i(12'd1, 5'd0, 3'd4, 5'd3, 7'h03));      // LBU x3,1(x0)
        prog.push_back(enc_i(12'd0, 5'd0, 3'd2, 5'd4, 7'h03));      // LW x4,0(x0)
        start_prog("mem");
        rst = 1'b0;
        finish_prog("mem");
        chk("mem store we", {28'h0, last_we}, 32'h2);
        chk("mem store addr", last_sa, 32'h0);
        chk("mem x2", dut.regfile_inst.regfile[2], 32'h7F);
        chk("mem x3", dut.regfile_inst.regfile[3], 32'h7F);
        chk("mem x4", dut.regfile_inst.regfile[4], 32'h7F00);

        // Step 4: arithmetic vs logical right shift
        prog = {};
        prog.push_back(enc_u(20'h80000, 5'd1, 7'h37));              // LUI x1,0x80000
        prog.push_back(enc_i(12'h404, 5'd1, 3'd5, 5'd2, 7'h13));    // SRAI x2,x1,4
        prog.push_back(enc_i(12'h004, 5'd1, 3'd5, 5'd3, 7'h13));    // SRLI x3,x1,4
        start_prog("shift");
        rst = 1'b0;
        finish_prog("shift");
        chk("shift x2", dut.regfile_inst.regfile[2], 32'hF800_0000);
        chk("shift x3", dut.regfile_inst.regfile[3], 32'h0800_0000);

        // Step 5: illegal instruction raises the flag in its DE cycle and freezes
        prog = {};
        prog.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13));      // ADDI x1,x0,1
        prog.push_back(32'h0000_006F);                               // JAL
        start_prog("ill");
        rst = 1'b0;
        @(negedge clk);
        chk("ill flag during ADDI", {31'h0, illegal}, 32'h0);
        @(negedge clk);
        chk("ill flag during JAL", {31'h0, illegal}, 32'h1);
        chk("ill no mem access", {28'h0, data_we}, 32'h0);
        finish_prog("ill");
        chk("ill x1", dut.regfile_inst.regfile[1], 32'h1);
        chk("ill pc", instr_addr, 32'h8);
        repeat (5) @(negedge clk);
        chk("ill pc still frozen", instr_addr, 32'h8);
        chk("ill flag sticky", {31'h0, illegal}, 32'h1);

        // Step 6: random programs with random RAM contents, including a
        // reset applied while a program is still running.
        for (int t = 0; t < 5; t++) begin
            prog = {};
            for (int i = 0; i < 24; i++) prog.push_back(rand_instr());
            for (int i = 0; i < 16; i++) ram_init[i] = $urandom;
            if (t == 2) begin
                start_prog("midrst");
                rst = 1'b0;
                repeat (6) @(negedge clk);
            end
            start_prog($sformatf("rand%0d", t));
            rst = 1'b0;
            finish_prog($sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
